// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-line round-robin request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NUM_REQ/IDX_W sizing, arbiter state enum, reset last-index,
//           one-hot to index helper.
package rr_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   // Reset value of the last-granted index: pointing at the top line makes
   // the first search after reset start at bit 0.
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Index of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) idx = idx | i[IDX_W-1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_req_arbiter_8_pick.sv
// Round-robin pick: first set bit of eff at or above last+1, wrapping 7->0.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: eff    - effective request vector
//        last   - index of the previously granted line
//        onehot - winning line as one-hot (zero when nothing requested)
//        idx    - winning line index (zero when nothing requested)
//        any    - at least one request present
module rr_pick_8
   import rr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] eff,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0]     start;
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     pos;

   always_comb begin
      // 3-bit add wraps naturally, so last=7 starts the search at 0.
      start = last + IDX_W'(1);
      // Rotate right so the search start lands on bit 0.
      dbl   = {eff, eff} >> start;
      rot   = dbl[NUM_REQ-1:0];
      // Descending scan so the lowest set bit of the rotated vector wins.
      pos   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) pos = i[IDX_W-1:0];
      end
      any    = |eff;
      // Rotate back: adding the start offset modulo NUM_REQ.
      idx    = any ? (pos + start) : '0;
      onehot = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/rr_req_arbiter_8.sv
// Round-robin arbiter: 8 sticky request lines, one held one-hot grant at a time.
// Latency: 1 cycle req->grant_valid; back-to-back grants with no bubble.
// Backpressure: grant held stable while grant_ready=0; requests keep accumulating.
// Ports: clk/rst     - clock, synchronous active-high reset
//        req         - request pulses/levels, latched into pending
//        grant       - registered one-hot grant, zero when not valid
//        grant_valid - grant holds a valid value
//        grant_ready - consumer accepts the grant this cycle
//        pending     - registered sticky request vector
module rr_req_arbiter_8
   import rr_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   input  logic               grant_ready,
   output logic [NUM_REQ-1:0] pending
);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;

   logic               hs;
   logic [IDX_W-1:0]   cur_idx;
   logic [NUM_REQ-1:0] clr;
   logic [NUM_REQ-1:0] pick_eff;
   logic [IDX_W-1:0]   pick_last;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   // One picker serves both cases: fresh arbitration from IDLE, and the
   // re-pick on a handshake edge (current grant excluded, search from it).
   // Outside a handshake in GRANT its result is simply ignored.
   rr_pick_8 u_pick (
      .eff    (pick_eff),
      .last   (pick_last),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      cur_idx   = oh2idx(grant_q);
      hs        = (state_q == GRANT) && grant_ready;
      clr       = hs ? grant_q : '0;
      pick_eff  = (state_q == GRANT) ? ((pending_q & ~grant_q) | req)
                                     : (pending_q | req);
      pick_last = (state_q == GRANT) ? cur_idx : last_q;

      // req is OR-ed in after the clear so a re-request on the accepting
      // edge survives as a new pending request.
      pending_d = (pending_q & ~clr) | req;
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_oh;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (hs) begin
               last_d = cur_idx;
               if (pick_any) begin
                  grant_d = pick_oh;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         grant_q   <= '0;
         last_q    <= LAST_RST;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = (state_q == GRANT);
   assign pending     = pending_q;

   // Cross-check: pick_idx must agree with the one-hot it produced.
   logic unused_idx_ok;
   assign unused_idx_ok = (pick_oh == (pick_any ? (NUM_REQ'(1) << pick_idx) : '0));

endmodule
